// File: rtl/axil_apb_bridge_if.sv
// APB4 bus bundle shared by the bridge (master side) and the peripheral
// segment (slave side). Widths follow the bridge's address/data parameters.
interface ApbIO #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [2:0]              pprot;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge. One-entry holding registers on AW, W
// and AR decouple the AXI handshakes from the APB sequencer, which serves one
// read or write at a time with read/write alternation on ties. A saturating
// ACCESS-phase counter turns a hung peripheral into an SLVERR response.
module axil_apb_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // write address
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [2:0]              awprot,
   // write data
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   // write response
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   // read address
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [2:0]              arprot,
   // read response
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   // APB master side
   ApbIO.master                    apb
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   // Last ACCESS cycle index that may still see pready before the forced error.
   localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_ZERO;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   // holding registers
   logic                  aw_valid_r;
   logic [ADDR_WIDTH-1:0] aw_addr_r;
   logic [2:0]            aw_prot_r;
   logic                  w_valid_r;
   logic [DATA_WIDTH-1:0] w_data_r;
   logic [STRB_W-1:0]     w_strb_r;
   logic                  ar_valid_r;
   logic [ADDR_WIDTH-1:0] ar_addr_r;
   logic [2:0]            ar_prot_r;

   // sequencer bookkeeping
   logic                  is_wr_r;        // transfer in flight is a write
   logic                  tie_to_write_r; // next read/write tie goes to the write
   logic [CNT_W-1:0]      tmo_cnt_r;

   // registered outputs
   logic [ADDR_WIDTH-1:0] paddr_r;
   logic [2:0]            pprot_r;
   logic                  psel_r;
   logic                  penable_r;
   logic                  pwrite_r;
   logic [DATA_WIDTH-1:0] pwdata_r;
   logic [STRB_W-1:0]     pstrb_r;
   logic                  bvalid_r;
   logic [1:0]            bresp_r;
   logic                  rvalid_r;
   logic [1:0]            rresp_r;
   logic [DATA_WIDTH-1:0] rdata_r;

   // decoded control
   logic wr_elig_s;
   logic rd_elig_s;
   logic grant_s;
   logic grant_wr_s;
   logic acc_done_s;
   logic tmo_s;
   logic tmo_hit_s;

   assign awready = ~aw_valid_r;
   assign wready  = ~w_valid_r;
   assign arready = ~ar_valid_r;

   assign bvalid  = bvalid_r;
   assign bresp   = bresp_r;
   assign rvalid  = rvalid_r;
   assign rresp   = rresp_r;
   assign rdata   = rdata_r;

   assign apb.paddr   = paddr_r;
   assign apb.pprot   = pprot_r;
   assign apb.psel    = psel_r;
   assign apb.penable = penable_r;
   assign apb.pwrite  = pwrite_r;
   assign apb.pwdata  = pwdata_r;
   assign apb.pstrb   = pstrb_r;

   assign wr_elig_s = aw_valid_r & w_valid_r;
   assign rd_elig_s = ar_valid_r;

   // Timeout fires on the TIMEOUT-th ACCESS cycle that has not seen pready.
   always_comb begin
      if ((TIMEOUT != 0) && (tmo_cnt_r >= TMO_LAST)) begin
         tmo_hit_s = 1'b1;
      end else begin
         tmo_hit_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic, arbitration and phase-completion strobes.
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = 1'b0;
      grant_wr_s  = 1'b0;
      acc_done_s  = 1'b0;
      tmo_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (wr_elig_s && rd_elig_s) begin
               grant_s     = 1'b1;
               grant_wr_s  = tie_to_write_r;
               state_nxt_s = ST_SETUP;
            end else if (wr_elig_s) begin
               grant_s     = 1'b1;
               grant_wr_s  = 1'b1;
               state_nxt_s = ST_SETUP;
            end else if (rd_elig_s) begin
               grant_s     = 1'b1;
               grant_wr_s  = 1'b0;
               state_nxt_s = ST_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nxt_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb.pready) begin
               acc_done_s  = 1'b1;
               state_nxt_s = ST_RESP;
            end else if (tmo_hit_s) begin
               tmo_s       = 1'b1;
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (is_wr_r ? bready : rready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // AW/W/AR holding registers: load on handshake, free when granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_valid_r <= 1'b0;
         aw_addr_r  <= {ADDR_WIDTH{1'b0}};
         aw_prot_r  <= 3'b000;
         w_valid_r  <= 1'b0;
         w_data_r   <= {DATA_WIDTH{1'b0}};
         w_strb_r   <= {STRB_W{1'b0}};
         ar_valid_r <= 1'b0;
         ar_addr_r  <= {ADDR_WIDTH{1'b0}};
         ar_prot_r  <= 3'b000;
      end else begin
         if (grant_s && grant_wr_s) begin
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
         end else begin
            if (awvalid && !aw_valid_r) begin
               aw_valid_r <= 1'b1;
               aw_addr_r  <= awaddr;
               aw_prot_r  <= awprot;
            end
            if (wvalid && !w_valid_r) begin
               w_valid_r <= 1'b1;
               w_data_r  <= wdata;
               w_strb_r  <= wstrb;
            end
         end
         if (grant_s && !grant_wr_s) begin
            ar_valid_r <= 1'b0;
         end else if (arvalid && !ar_valid_r) begin
            ar_valid_r <= 1'b1;
            ar_addr_r  <= araddr;
            ar_prot_r  <= arprot;
         end
      end
   end

   // Grant bookkeeping: direction of the current transfer and tie alternation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_wr_r        <= 1'b0;
         tie_to_write_r <= 1'b0;
      end else if (grant_s) begin
         is_wr_r        <= grant_wr_s;
         tie_to_write_r <= ~grant_wr_s;
      end
   end

   // ACCESS-phase cycle counter: cleared on SETUP entry, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= CNT_ZERO;
      end else if (grant_s) begin
         tmo_cnt_r <= CNT_ZERO;
      end else if ((state_r == ST_ACCESS) && (tmo_cnt_r != CNT_MAX)) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
      end
   end

   // APB request signals: launched on grant, held stable until ACCESS ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psel_r    <= 1'b0;
         penable_r <= 1'b0;
         pwrite_r  <= 1'b0;
         paddr_r   <= {ADDR_WIDTH{1'b0}};
         pprot_r   <= 3'b000;
         pwdata_r  <= {DATA_WIDTH{1'b0}};
         pstrb_r   <= {STRB_W{1'b0}};
      end else if (grant_s) begin
         psel_r    <= 1'b1;
         penable_r <= 1'b0;
         pwrite_r  <= grant_wr_s;
         paddr_r   <= grant_wr_s ? aw_addr_r : ar_addr_r;
         pprot_r   <= grant_wr_s ? aw_prot_r : ar_prot_r;
         pwdata_r  <= grant_wr_s ? w_data_r : {DATA_WIDTH{1'b0}};
         pstrb_r   <= grant_wr_s ? w_strb_r : {STRB_W{1'b0}};
      end else if (state_r == ST_SETUP) begin
         penable_r <= 1'b1;
      end else if (acc_done_s || tmo_s) begin
         psel_r    <= 1'b0;
         penable_r <= 1'b0;
      end
   end

   // AXI response channels: loaded when ACCESS ends, held until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bvalid_r <= 1'b0;
         bresp_r  <= 2'b00;
         rvalid_r <= 1'b0;
         rresp_r  <= 2'b00;
         rdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_ACCESS: begin
               if (acc_done_s) begin
                  if (is_wr_r) begin
                     bvalid_r <= 1'b1;
                     bresp_r  <= apb.pslverr ? 2'b10 : 2'b00;
                  end else begin
                     rvalid_r <= 1'b1;
                     rresp_r  <= apb.pslverr ? 2'b10 : 2'b00;
                     rdata_r  <= apb.prdata;
                  end
               end else if (tmo_s) begin
                  if (is_wr_r) begin
                     bvalid_r <= 1'b1;
                     bresp_r  <= 2'b10;
                  end else begin
                     rvalid_r <= 1'b1;
                     rresp_r  <= 2'b10;
                     rdata_r  <= {DATA_WIDTH{1'b0}};
                  end
               end
            end
            ST_RESP: begin
               if (bvalid_r && bready) begin
                  bvalid_r <= 1'b0;
               end
               if (rvalid_r && rready) begin
                  rvalid_r <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Self-checking bench for axil_apb_bridge: reset values, exact latency of a
// zero-wait write, a table of directed transfers, AW/W skew, timeout, tie
// arbitration, reset during ACCESS, and random traffic against a memory model.
module tb_axil_apb_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   ApbIO #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

   axil_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .apb(apb)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- APB slave model ----------------
   int          slv_waits = 0;
   bit          slv_err = 1'b0, slv_hang = 1'b0, slv_use_mem = 1'b0;
   logic [31:0] slv_rdata = 32'h0;
   logic [31:0] slv_mem [logic [31:0]];
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_strb;
   logic [2:0]  cap_prot;
   logic        cap_write;
   int          n_xfer = 0, pen_run = 0, last_pen_len = 0;
   bit          wr_order [$];

   function automatic logic [31:0] slv_get(input logic [31:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
   endfunction

   initial begin
      logic [31:0] cur;
      apb.pready = 1'b0; apb.prdata = 32'h0; apb.pslverr = 1'b0;
      forever begin
         @(negedge clk);
         if (apb.psel && apb.penable) begin
            pen_run++;
            if (!slv_hang && pen_run == slv_waits + 1) begin
               apb.pready  = 1'b1;
               apb.pslverr = slv_err;
               apb.prdata  = slv_use_mem ? slv_get(apb.paddr) : slv_rdata;
               cap_addr = apb.paddr; cap_wdata = apb.pwdata; cap_strb = apb.pstrb;
               cap_prot = apb.pprot; cap_write = apb.pwrite;
               if (apb.pwrite) begin
                  cur = slv_get(apb.paddr);
                  for (int b = 0; b < 4; b++)
                     if (apb.pstrb[b]) cur[8*b +: 8] = apb.pwdata[8*b +: 8];
                  slv_mem[apb.paddr] = cur;
               end
               n_xfer++;
               wr_order.push_back(apb.pwrite);
            end else begin
               apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = 32'h0;
            end
         end else begin
            if (pen_run != 0) last_pen_len = pen_run;
            pen_run = 0;
            apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = 32'h0;
         end
      end
   end

   // ---------------- reference memory for random traffic ----------------
   logic [31:0] model_mem [logic [31:0]];

   function automatic logic [31:0] model_get(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : 32'h0;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;
      bit          err;
      int          rdly;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [2:0] prot, input int waits,
                               input bit err, input int rdly, input logic [1:0] exp_resp,
                               input logic [31:0] exp_rdata);
      vec_t v;
      v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.prot = prot;
      v.waits = waits; v.err = err; v.rdly = rdly; v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
      return v;
   endfunction

   // ---------------- AXI master helpers ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      awaddr = 32'h0; awprot = 3'b000; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0; arprot = 3'b000;
      slv_hang = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_xact(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input bit err, input int rdly, input logic [1:0] exp_resp,
                           input logic [31:0] exp_rdata, input bit chk_apb);
      int nx;
      bit hs_aw, hs_w, hs_ar;
      nx = n_xfer;
      slv_waits = waits; slv_err = err; slv_rdata = data;
      @(negedge clk);
      if (wr) begin
         awvalid = 1'b1; awaddr = addr; awprot = prot;
         wvalid = 1'b1; wdata = data; wstrb = strb;
      end else begin
         arvalid = 1'b1; araddr = addr; arprot = prot;
      end
      for (int i = 0; i < 50; i++) begin
         if (!(awvalid || wvalid || arvalid)) break;
         hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_ar = arvalid && arready;
         @(negedge clk);
         if (hs_aw) awvalid = 1'b0;
         if (hs_w)  wvalid = 1'b0;
         if (hs_ar) arvalid = 1'b0;
      end
      chk("req_accepted", {31'b0, awvalid | wvalid | arvalid}, 32'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (wr ? bvalid : rvalid) break;
         @(negedge clk);
      end
      chk("resp_valid", {31'b0, (wr ? bvalid : rvalid)}, 32'd1);
      for (int i = 0; i < rdly; i++) begin
         chk("hold_valid", {31'b0, (wr ? bvalid : rvalid)}, 32'd1);
         chk("hold_resp", {30'b0, (wr ? bresp : rresp)}, {30'b0, exp_resp});
         if (!wr) chk("hold_rdata", rdata, exp_rdata);
         @(negedge clk);
      end
      if (wr) bready = 1'b1; else rready = 1'b1;
      chk(wr ? "bresp" : "rresp", {30'b0, (wr ? bresp : rresp)}, {30'b0, exp_resp});
      if (!wr) chk("rdata", rdata, exp_rdata);
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      chk("valid_drop", {31'b0, (wr ? bvalid : rvalid)}, 32'd0);
      if (chk_apb) begin
         chk("apb_xfers", n_xfer - nx, 32'd1);
         chk("paddr", cap_addr, addr);
         chk("pwrite", {31'b0, cap_write}, {31'b0, wr});
         chk("pwdata", cap_wdata, wr ? data : 32'h0);
         chk("pstrb", {28'b0, cap_strb}, wr ? {28'b0, strb} : 32'h0);
         chk("pprot", {29'b0, cap_prot}, {29'b0, prot});
      end
   endtask

   vec_t tbl [7];

   initial begin
      logic [31:0] a, d, cur;
      logic [3:0]  s;
      logic [2:0]  p;
      bit          wr, er;
      int          idx;

      tbl[0] = mk(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 0, 2'b00, 32'h0);
      tbl[1] = mk(1'b0, 32'h1000_0008, 32'h1234_5678, 4'h0, 3'b000, 3, 1'b0, 3, 2'b00, 32'h1234_5678);
      tbl[2] = mk(1'b1, 32'h3000_0000, 32'h0BAD_0BAD, 4'hF, 3'b001, 1, 1'b1, 1, 2'b10, 32'h0);
      tbl[3] = mk(1'b0, 32'h3000_0000, 32'hCAFE_F00D, 4'h0, 3'b001, 0, 1'b0, 0, 2'b00, 32'hCAFE_F00D);
      tbl[4] = mk(1'b0, 32'h3000_0004, 32'h5555_AAAA, 4'h0, 3'b100, 2, 1'b1, 2, 2'b10, 32'h5555_AAAA);
      tbl[5] = mk(1'b1, 32'h2000_0020, 32'h0102_0304, 4'h5, 3'b101, 5, 1'b0, 2, 2'b00, 32'h0);
      tbl[6] = mk(1'b0, 32'hFFFF_FFFC, 32'h8000_0001, 4'h0, 3'b010, 0, 1'b0, 1, 2'b00, 32'h8000_0001);

      do_reset();

      // reset values
      chk("rst_awready", {31'b0, awready}, 32'd1);
      chk("rst_wready", {31'b0, wready}, 32'd1);
      chk("rst_arready", {31'b0, arready}, 32'd1);
      chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_resp", {28'b0, bresp, rresp}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_psel_penable_pwrite", {29'b0, apb.psel, apb.penable, apb.pwrite}, 32'd0);
      chk("rst_paddr", apb.paddr, 32'h0);
      chk("rst_pwdata", apb.pwdata, 32'h0);
      chk("rst_pstrb_pprot", {25'b0, apb.pstrb, apb.pprot}, 32'd0);

      // zero-wait write, cycle-exact latency
      slv_waits = 0; slv_err = 1'b0; slv_use_mem = 1'b0;
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h1000_0004; awprot = 3'b000;
      wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("lat_idle_psel", {31'b0, apb.psel}, 32'd0);
      chk("lat_regs_full", {30'b0, awready, wready}, 32'd0);
      @(negedge clk);
      chk("lat_setup", {30'b0, apb.psel, apb.penable}, 32'b10);
      chk("lat_setup_pwrite", {31'b0, apb.pwrite}, 32'd1);
      chk("lat_setup_paddr", apb.paddr, 32'h1000_0004);
      chk("lat_setup_pwdata", apb.pwdata, 32'hDEAD_BEEF);
      chk("lat_regs_freed", {30'b0, awready, wready}, 32'b11);
      @(negedge clk);
      chk("lat_access", {30'b0, apb.psel, apb.penable}, 32'b11);
      chk("lat_access_bvalid", {31'b0, bvalid}, 32'd0);
      @(negedge clk);
      chk("lat_resp_bvalid", {31'b0, bvalid}, 32'd1);
      chk("lat_resp_bresp", {30'b0, bresp}, 32'd0);
      chk("lat_resp_psel", {31'b0, apb.psel}, 32'd0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("lat_bvalid_drop", {31'b0, bvalid}, 32'd0);

      // directed table
      for (int i = 0; i < 7; i++)
         run_xact(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].prot, tbl[i].waits,
                  tbl[i].err, tbl[i].rdly, tbl[i].exp_resp, tbl[i].exp_rdata, 1'b1);

      // W arrives well ahead of AW
      slv_waits = 0; slv_err = 1'b0;
      @(negedge clk);
      wvalid = 1'b1; wdata = 32'hA5A5_0F0F; wstrb = 4'h3;
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("skew_no_apb", {31'b0, apb.psel}, 32'd0);
         chk("skew_wready_low", {31'b0, wready}, 32'd0);
         @(negedge clk);
      end
      awvalid = 1'b1; awaddr = 32'h2000_0010; awprot = 3'b000;
      @(negedge clk);
      awvalid = 1'b0;
      chk("skew_idle_wready", {31'b0, wready}, 32'd0);
      @(negedge clk);
      chk("skew_setup_psel", {31'b0, apb.psel}, 32'd1);
      chk("skew_setup_wready", {31'b0, wready}, 32'd1);
      chk("skew_pwdata", apb.pwdata, 32'hA5A5_0F0F);
      chk("skew_pstrb", {28'b0, apb.pstrb}, 32'h3);
      for (int i = 0; i < 20; i++) begin
         if (bvalid) break;
         @(negedge clk);
      end
      chk("skew_bvalid", {31'b0, bvalid}, 32'd1);
      chk("skew_bresp", {30'b0, bresp}, 32'd0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;

      // hung slave -> timeout after 8 ACCESS cycles
      slv_hang = 1'b1;
      run_xact(1'b0, 32'h5000_0000, 32'h7777_7777, 4'h0, 3'b000, 0, 1'b0, 2, 2'b10, 32'h0, 1'b0);
      chk("tmo_access_len", last_pen_len, 32'd8);
      chk("tmo_psel_low", {31'b0, apb.psel}, 32'd0);
      slv_hang = 1'b0;
      run_xact(1'b0, 32'h5000_0004, 32'h0F0F_1234, 4'h0, 3'b000, 1, 1'b0, 0, 2'b00, 32'h0F0F_1234, 1'b1);

      // random traffic against the reference memory
      slv_use_mem = 1'b1;
      slv_mem.delete();
      model_mem.delete();
      for (int n = 0; n < 40; n++) begin
         wr  = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, 7);
         a   = 32'h4000_0000 + 32'(idx * 4);
         d   = $urandom;
         s   = 4'($urandom_range(0, 15));
         p   = 3'($urandom_range(0, 7));
         er  = ($urandom_range(0, 3) == 0);
         if (wr) begin
            cur = model_get(a);
            for (int b = 0; b < 4; b++)
               if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
            model_mem[a] = cur;
            run_xact(1'b1, a, d, s, p, $urandom_range(0, 5), er, $urandom_range(0, 3),
                     er ? 2'b10 : 2'b00, 32'h0, 1'b1);
         end else begin
            run_xact(1'b0, a, 32'h0, 4'h0, p, $urandom_range(0, 5), er, $urandom_range(0, 3),
                     er ? 2'b10 : 2'b00, model_get(a), 1'b0);
         end
      end
      slv_use_mem = 1'b0;

      // tie arbitration from reset: read, write, read
      do_reset();
      slv_waits = 1; slv_err = 1'b0;
      bready = 1'b1; rready = 1'b1;
      wr_order.delete();
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h6000_0000; wvalid = 1'b1; wdata = 32'h1111_1111; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h6000_0004;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (arready) break;
         @(negedge clk);
      end
      arvalid = 1'b1; araddr = 32'h6000_0008;
      @(negedge clk);
      arvalid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (awready && wready) break;
         @(negedge clk);
      end
      awvalid = 1'b1; awaddr = 32'h6000_000C; wvalid = 1'b1; wdata = 32'h2222_2222;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (wr_order.size() >= 4) break;
         @(negedge clk);
      end
      chk("tie_count", wr_order.size(), 32'd4);
      if (wr_order.size() >= 3) begin
         chk("tie_first_read", {31'b0, wr_order[0]}, 32'd0);
         chk("tie_second_write", {31'b0, wr_order[1]}, 32'd1);
         chk("tie_third_read", {31'b0, wr_order[2]}, 32'd0);
      end
      repeat (4) @(negedge clk);
      bready = 1'b0; rready = 1'b0;

      // reset asserted during ACCESS
      slv_hang = 1'b1;
      awvalid = 1'b1; awaddr = 32'h7000_0000;
      arvalid = 1'b1; araddr = 32'h7000_0004;
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (apb.penable) break;
         @(negedge clk);
      end
      chk("rstmid_in_access", {31'b0, apb.penable}, 32'd1);
      chk("rstmid_aw_pending", {31'b0, awready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_psel_penable", {30'b0, apb.psel, apb.penable}, 32'd0);
      chk("rstmid_readys", {29'b0, awready, wready, arready}, 32'b111);
      chk("rstmid_valids", {30'b0, bvalid, rvalid}, 32'd0);
      chk("rstmid_paddr", apb.paddr, 32'h0);
      slv_hang = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstmid_dropped", {31'b0, apb.psel}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
